// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter: owns the single-port ROM/program RAM shared by the ioctl
// download path and the arcade core. Download writes are buffered in a small
// FIFO and always win the RAM; otherwise video and CPU fetches share it, with
// a starvation counter guaranteeing the CPU a slot after STARVE_MAX video wins.
module rom_dl_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dn_download,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [DW-1:0] dn_data,
    output logic          dn_overflow,
    output logic          dl_done,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_data,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

    state_t          state_q, state_d;
    logic            grant_wr, grant_cpu, grant_vid;
    logic            owner_cpu;
    logic [SW-1:0]   starve_q;
    logic            dl_seen_q;

    logic [AW-1:0]   fifo_addr [FIFO_DEPTH];
    logic [DW-1:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign pop        = grant_wr;
    // A pop in the same cycle frees a slot, so a strobe into a full FIFO is
    // still accepted when a write is being granted.
    assign push       = dn_wr && (!fifo_full || pop);

    // Download is complete once the level falls, the buffer is empty and the
    // final write has left WR.
    assign dl_done = dl_seen_q && !dn_download && fifo_empty && (state_q != WR);

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= dn_addr;
            fifo_data[wr_ptr] <= dn_data;
        end
    end

    // FIFO pointers, occupancy, overflow flag and download-seen tracking.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dn_overflow <= 1'b0;
            dl_seen_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (dn_wr && !push) dn_overflow <= 1'b1;
            if (dn_download)  dl_seen_q <= 1'b1;
            else if (dl_done) dl_seen_q <= 1'b0;
        end
    end

    // Starvation counter: counts video wins while the CPU is waiting.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!cpu_req || grant_cpu) begin
            starve_q <= '0;
        end else if (grant_vid && (starve_q != SW'(STARVE_MAX))) begin
            starve_q <= starve_q + SW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Arbitration and next-state: buffered writes first, then a forced CPU
    // slot, then video, then CPU. Reads wait for the download to finish.
    always_comb begin
        state_d   = state_q;
        grant_wr  = 1'b0;
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    grant_wr = 1'b1;
                    state_d  = WR;
                end else if (!dn_download) begin
                    if (cpu_req && (starve_q == SW'(STARVE_MAX))) grant_cpu = 1'b1;
                    else if (vid_req)                               grant_vid = 1'b1;
                    else if (cpu_req)                               grant_cpu = 1'b1;
                    if (grant_cpu || grant_vid) state_d = RD1;
                end
            end
            WR:      state_d = IDLE;
            RD1:     state_d = RD2;
            RD2:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port registers and read-data return to the owning requester.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_we    <= 1'b0;
            owner_cpu <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
            cpu_data  <= '0;
            vid_data  <= '0;
        end else begin
            mem_we  <= grant_wr;
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            if (grant_wr) begin
                mem_addr <= fifo_addr[rd_ptr];
                mem_din  <= fifo_data[rd_ptr];
            end else if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                owner_cpu <= 1'b1;
            end else if (grant_vid) begin
                mem_addr  <= vid_addr;
                owner_cpu <= 1'b0;
            end
            if (state_q == RD2) begin
                if (owner_cpu) begin
                    cpu_data <= mem_dout;
                    cpu_ack  <= 1'b1;
                end else begin
                    vid_data <= mem_dout;
                    vid_ack  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Directed testbench for rom_dl_arbiter with a behavioural synchronous RAM.
module tb_rom_dl_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dn_download, dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_overflow, dl_done;
    logic        cpu_req, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        vid_req, vid_ack;
    logic [15:0] vid_addr;
    logic [7:0]  vid_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_we;

    logic [7:0]  ram [65536];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0, cpu_ack_cnt = 0, dl_cnt = 0, dl_cyc = 0;
    logic [15:0] we_addr_q [$];
    int          we_cyc_q  [$];
    logic        ack_log   [$];

    rom_dl_arbiter #(.AW(16), .DW(8), .FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .dn_overflow(dn_overflow), .dl_done(dl_done),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous RAM, one-cycle read latency.
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (mem_we) begin
            we_cnt = we_cnt + 1;
            we_addr_q.push_back(mem_addr);
            we_cyc_q.push_back(cyc);
        end
        if (cpu_ack) begin
            cpu_ack_cnt = cpu_ack_cnt + 1;
            ack_log.push_back(1'b1);
        end
        if (vid_ack) ack_log.push_back(1'b0);
        if (dl_done) begin
            dl_cnt = dl_cnt + 1;
            dl_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int base, ab, we0, ack0, dl0;
        logic [15:0] ea;

        for (int i = 0; i < 65536; i++) ram[i] = 8'hEE;
        ram[16'h1234] = 8'hA5;
        ram[16'h2000] = 8'h3C;
        reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; vid_req = 1'b0; vid_addr = '0;

        // Reset values
        repeat (3) tick();
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_overflow", dn_overflow, 0);
        check("rst_dl_done", dl_done, 0);
        check("rst_cpu_data", cpu_data, 0);

        // CPU read at 0x1234, request dropped after grant; ack 3 cycles after grant
        reset = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h1234;
        tick();
        check("rd_mem_addr", mem_addr, 16'h1234);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_early", cpu_ack, 0);
        tick();
        check("rd_ack", cpu_ack, 1);
        check("rd_data", cpu_data, 8'hA5);
        tick();
        check("rd_ack_once", cpu_ack, 0);
        check("rd_data_held", cpu_data, 8'hA5);
        check("rd_no_we", we_cnt, 0);

        // Starvation: vid and cpu held -> v,v,v,c,v,v,v,c
        ab = ack_log.size();
        vid_req = 1'b1; vid_addr = 16'h2000; cpu_req = 1'b1; cpu_addr = 16'h1234;
        repeat (25) tick();
        vid_req = 1'b0; cpu_req = 1'b0;
        repeat (4) tick();
        check("starve_cnt", (ack_log.size() - ab >= 8) ? 1 : 0, 1);
        for (int k = 0; k < 8; k++)
            if (ab + k < ack_log.size())
                check($sformatf("starve_grant%0d", k), ack_log[ab + k], (k % 4 == 3) ? 1 : 0);
        check("starve_vid_data", vid_data, 8'h3C);
        check("starve_cpu_data", cpu_data, 8'hA5);

        // CPU blocked during download
        ack0 = cpu_ack_cnt;
        dn_download = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h1234;
        tick();
        dn_wr = 1'b1; dn_addr = 16'h3000; dn_data = 8'h77;
        tick();
        dn_wr = 1'b0;
        repeat (5) tick();
        check("blk_no_ack", cpu_ack_cnt - ack0, 0);
        check("blk_write", ram[16'h3000], 8'h77);
        dn_download = 1'b0;
        #1;
        check("blk_dl_done", dl_done, 1);
        tick();
        tick();
        check("blk_ack_early", cpu_ack, 0);
        tick();
        check("blk_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        tick();

        // Burst of 10 back-to-back strobes into a 4-deep FIFO; address 0x0108 dropped
        base = we_addr_q.size();
        dn_download = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dn_wr = 1'b1; dn_addr = 16'h0100 + 16'(i); dn_data = 8'h10 + 8'(i);
            tick();
        end
        dn_wr = 1'b0;
        repeat (20) tick();
        dn_download = 1'b0;
        repeat (3) tick();
        check("ovf_flag", dn_overflow, 1);
        check("ovf_we_cnt", we_addr_q.size() - base, 9);
        for (int k = 0; k < 9; k++) begin
            ea = 16'h0100 + ((k < 8) ? 16'(k) : 16'd9);
            if (base + k < we_addr_q.size())
                check($sformatf("ovf_order%0d", k), we_addr_q[base + k], ea);
        end
        if (base + 1 < we_cyc_q.size())
            check("ovf_spacing", we_cyc_q[base + 1] - we_cyc_q[base], 2);
        check("ovf_ram7", ram[16'h0107], 8'h17);
        check("ovf_ram8_untouched", ram[16'h0108], 8'hEE);
        check("ovf_ram9", ram[16'h0109], 8'h19);

        // Reset with a read in flight and download data arriving
        cpu_req = 1'b1; cpu_addr = 16'h1234;
        dn_wr = 1'b1; dn_addr = 16'h4000; dn_data = 8'h99;
        tick();
        dn_addr = 16'h4001; reset = 1'b1;
        tick();
        check("mrst_mem_we", mem_we, 0);
        check("mrst_cpu_ack", cpu_ack, 0);
        check("mrst_overflow", dn_overflow, 0);
        check("mrst_mem_addr", mem_addr, 0);
        reset = 1'b0; cpu_req = 1'b0; dn_wr = 1'b0;
        we0 = we_cnt; ack0 = cpu_ack_cnt;
        repeat (6) tick();
        check("mrst_no_ack", cpu_ack_cnt - ack0, 0);
        check("mrst_no_we", we_cnt - we0, 0);
        check("mrst_ram4000", ram[16'h4000], 8'hEE);

        // 16 bytes spaced 4 cycles, then download ends
        base = we_addr_q.size(); dl0 = dl_cnt;
        dn_download = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dn_wr = 1'b1; dn_addr = 16'h0200 + 16'(i); dn_data = 8'hC0 + 8'(i);
            tick();
            dn_wr = 1'b0;
            repeat (3) tick();
        end
        dn_download = 1'b0;
        repeat (6) tick();
        check("dl16_we_cnt", we_addr_q.size() - base, 16);
        for (int k = 0; k < 16; k++)
            if (base + k < we_addr_q.size())
                check($sformatf("dl16_order%0d", k), we_addr_q[base + k], 16'h0200 + 16'(k));
        check("dl16_ram_last", ram[16'h020F], 8'hCF);
        check("dl16_done_cnt", dl_cnt - dl0, 1);
        if (we_cyc_q.size() > 0)
            check("dl16_done_after_wr", (dl_cyc > we_cyc_q[we_cyc_q.size() - 1]) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
